// File: rtl/seq_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_div
//  Purpose  : 8-bit / 4-bit unsigned radix-2 restoring divider. One trial
//             subtraction per RUN cycle, MSB of the dividend first. The result
//             appears 8 RUN cycles after acceptance, or 1 cycle after it when
//             the divisor is zero.
//  Ports    : clk    - clock, rising edge
//             rst_n  - synchronous active-low reset
//             start  - begin a division (accepted in IDLE or DONE)
//             a      - dividend, latched on the accepting edge
//             b      - divisor, latched on the accepting edge
//             q      - quotient, registered, updated only on entry to DONE
//             r      - remainder, registered, updated only on entry to DONE
//             busy   - division in progress (RUN)
//             done   - q/r hold the most recent accepted result (DONE)
//             dbz    - divide-by-zero flag for the most recent result
//  Revision : 1.0 - initial release
// ============================================================================
module seq_div (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [3:0] b,
    output logic [7:0] q,
    output logic [3:0] r,
    output logic       busy,
    output logic       done,
    output logic       dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [2:0] r_cnt;     // RUN cycles completed
    logic [3:0] r_rem;     // partial remainder, always < divisor
    logic [7:0] r_dvd;     // dividend bits shift out, quotient bits shift in
    logic [3:0] r_b;       // latched divisor
    logic       r_zero;    // latched divisor was zero

    logic       w_accept;
    logic       w_last;
    logic [4:0] w_shift;
    logic [4:0] w_diff;
    logic       w_qbit;
    logic [3:0] w_rem_nxt;

    always_comb begin
        w_accept = start && (r_state != RUN);
        w_last   = r_zero || (r_cnt == 3'd7);
        // Partial remainder is below b, so 2*rem+1 <= 2b-1 and the
        // difference lies in [-b, b-1]; bit 4 is therefore a valid sign.
        w_shift   = {r_rem, r_dvd[7]};
        w_diff    = w_shift - {1'b0, r_b};
        w_qbit    = ~w_diff[4];
        w_rem_nxt = w_qbit ? w_diff[3:0] : w_shift[3:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DONE;
            DONE:    if (w_accept) w_state_nxt = RUN;
            default:               w_state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 3'd0;
            r_rem  <= 4'd0;
            r_dvd  <= 8'd0;
            r_b    <= 4'd0;
            r_zero <= 1'b0;
            q      <= 8'd0;
            r      <= 4'd0;
            dbz    <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= 3'd0;
            r_rem  <= 4'd0;
            r_dvd  <= a;
            r_b    <= b;
            r_zero <= (b == 4'd0);
            dbz    <= 1'b0;
        end else if (r_state == RUN) begin
            if (r_zero) begin
                q   <= 8'hFF;
                r   <= 4'h0;
                dbz <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 3'd1;
                r_rem <= w_rem_nxt;
                r_dvd <= {r_dvd[6:0], w_qbit};
                if (w_last) begin
                    q <= {r_dvd[6:0], w_qbit};
                    r <= w_rem_nxt;
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seq_div
//  Purpose  : Scoreboard bench for seq_div. Accepted operations push an
//             expected result computed with integer arithmetic; a monitor
//             pops and checks whenever done rises, and checks that q/r stay
//             stable while busy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'd0;
    logic [3:0] b = 4'd0;
    logic [7:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dbz;

    seq_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] eq;
        logic [3:0] er;
        logic       edbz;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] last_q = 8'd0;
    logic [3:0] last_r = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (busy === 1'b1) begin
                tests++;
                if (q !== last_q || r !== last_r || done !== 1'b0) begin
                    fails++;
                    $display("FAIL hold cyc=%0d: q=%0d r=%0d done=%b, required q=%0d r=%0d done=0",
                             cyc, q, r, done, last_q, last_r);
                end
            end
            if (done === 1'b1 && prev_done !== 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL result cyc=%0d: done rose with no pending operation", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (q !== e.eq || r !== e.er || dbz !== e.edbz ||
                        busy !== 1'b0 || (cyc - e.acc + 1) != e.lat) begin
                        fails++;
                        $display("FAIL result cyc=%0d: q=%0d r=%0d dbz=%b busy=%b lat=%0d, required q=%0d r=%0d dbz=%b busy=0 lat=%0d",
                                 cyc, q, r, dbz, busy, cyc - e.acc + 1, e.eq, e.er, e.edbz, e.lat);
                    end
                    last_q = e.eq;
                    last_r = e.er;
                end
            end
            prev_done = done;
        end
    end

    task automatic check_zero(input string name);
        tests++;
        if (q !== 8'd0 || r !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
            fails++;
            $display("FAIL %s: q=%0d r=%0d busy=%b done=%b dbz=%b, required all 0",
                     name, q, r, busy, done, dbz);
        end
    endtask

    // Issue one operation once the DUT can accept it; keep=1 leaves start high.
    task automatic do_op(input logic [7:0] av, input logic [3:0] bv, input bit keep);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #2;
        while (busy !== 1'b0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (busy !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL accept-timeout: busy=%b, required 0", busy);
            return;
        end
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        e.acc = cyc;
        if (bv == 4'd0) begin
            e.eq = 8'hFF; e.er = 4'h0; e.edbz = 1'b1; e.lat = 2;
        end else begin
            e.eq = 8'(int'(av) / int'(bv));
            e.er = 4'(int'(av) % int'(bv));
            e.edbz = 1'b0;
            e.lat = 9;
        end
        sb.push_back(e);
        if (!keep) begin
            start = 1'b0;
            a = 8'($urandom);
            b = 4'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #2;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic scenario
        do_op(8'd200, 4'd7, 1'b0);
        drain();

        // Back-to-back from DONE
        do_op(8'd255, 4'd1, 1'b0);
        do_op(8'd5, 4'd9, 1'b0);
        drain();

        // Divide by zero followed by normal op
        do_op(8'd100, 4'd0, 1'b0);
        do_op(8'd15, 4'd4, 1'b0);
        drain();

        // Start pulse during RUN cycle 3 is ignored
        do_op(8'd200, 4'd7, 1'b0);
        repeat (2) @(posedge clk);
        #2 start = 1'b1; a = 8'd9; b = 4'd2;
        @(posedge clk);
        #2 start = 1'b0;
        drain();

        // Reset during RUN cycle 4 abandons the operation
        do_op(8'd240, 4'd15, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero("reset-in-run");
        sb.delete();
        last_q = 8'd0;
        last_r = 4'd0;
        prev_done = 1'b0;
        #1 rst_n = 1'b1;
        do_op(8'd15, 4'd4, 1'b0);
        drain();

        // Reset wins over start in DONE
        #2 rst_n = 1'b0; start = 1'b1; a = 8'd15; b = 4'd4;
        @(posedge clk); #1;
        check_zero("reset-priority");
        last_q = 8'd0;
        last_r = 4'd0;
        prev_done = 1'b0;
        #1 rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check_zero("idle-after-reset");

        // Randomized ops, some with start held high across operations
        for (int i = 0; i < 300; i++) begin
            do_op(8'($urandom), 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end
        do_op(8'($urandom), 4'($urandom_range(1, 15)), 1'b0);
        drain();

        // Exhaustive sweep of nonzero divisors
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 1; bi < 16; bi++) begin
                do_op(8'(ai), 4'(bi), 1'b0);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
